// File: rtl/reg_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_pkg
// Description : Shared types and constants for the register-bus initiator.
//               It provides the FSM state encoding and the address/data widths.
//               It also lists the register-bank address map and a predicate
//               that reports whether an address is mapped.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bus_pkg;

   localparam int c_addr_w = 4;
   localparam int c_data_w = 8;

   typedef logic [c_addr_w-1:0] addr_t;
   typedef logic [c_data_w-1:0] data_t;

   // Register-bank address map. Addresses 3..7 are not populated.
   localparam addr_t c_adr_ctrl0 = 4'd0;
   localparam addr_t c_adr_ctrl1 = 4'd1;
   localparam addr_t c_adr_ctrl2 = 4'd2;
   localparam addr_t c_adr_data1 = 4'd8;
   localparam addr_t c_adr_data2 = 4'd9;
   localparam addr_t c_adr_data3 = 4'd10;
   localparam addr_t c_adr_data4 = 4'd11;
   localparam addr_t c_adr_data5 = 4'd12;
   localparam addr_t c_adr_data6 = 4'd13;
   localparam addr_t c_adr_data7 = 4'd14;
   localparam addr_t c_adr_data8 = 4'd15;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR   = 3'd1,
      S_LATCH  = 3'd2,
      S_ENABLE = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   // The predicate returns true when the address hits a populated register.
   function automatic logic is_mapped(input addr_t addr);
      return (addr <= c_adr_ctrl2) || (addr >= c_adr_data1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bus_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_initiator_if
// Description : Bundles the host request/response handshake and the
//               register-bank bus that the initiator drives.
//   master : the initiator. It drives req_ready, the rsp_* signals, regAdr,
//            clk_AdrLatch, enable_output, bus_wdata and bus_we.
//   slave  : the host and decoder side. It drives the req_* signals and
//            bus_rdata.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_bus_initiator_if;
   import reg_bus_pkg::*;

   // host side
   logic  req_valid;
   logic  req_ready;
   logic  req_write;
   addr_t req_addr;
   data_t req_wdata;
   logic  rsp_valid;
   data_t rsp_rdata;
   logic  rsp_err;

   // register-bank side
   addr_t regAdr;
   logic  clk_AdrLatch;
   logic  enable_output;
   data_t bus_wdata;
   logic  bus_we;
   data_t bus_rdata;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, bus_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             regAdr, clk_AdrLatch, enable_output, bus_wdata, bus_we
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, bus_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             regAdr, clk_AdrLatch, enable_output, bus_wdata, bus_we
   );

endinterface
`default_nettype wire

// File: rtl/reg_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_initiator
// Description : This module accepts one register access at a time from a host.
//               It runs the access on a strobed register bus with these phases:
//                 1. address setup
//                 2. address-latch strobe
//                 3. ENABLE_CYCLES of enable
//               A one-cycle response follows the enable phase.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - reg_bus_initiator_if.master (host handshake + reg bus)
// Parameter   : ENABLE_CYCLES - enable_output high time per access (1..15)
// Option      : REG_BUS_ADDR_CHECK_EN - when defined, accesses to unmapped
//               addresses (3..7) are answered at once with rsp_err=1. In that
//               case no strobe or enable is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_initiator
   import reg_bus_pkg::*;
#(
   parameter int ENABLE_CYCLES = 2
)
(
   input  logic                clk,
   input  logic                rst_n,
   reg_bus_initiator_if.master bus
);

   localparam logic [3:0] c_cnt_load = 4'(ENABLE_CYCLES - 1);

   // FSM and captured request
   state_t     r_state,  w_state_nxt;
   logic [3:0] r_cnt,    w_cnt_nxt;
   addr_t      r_addr,   w_addr_nxt;
   data_t      r_wdata,  w_wdata_nxt;
   logic       r_write,  w_write_nxt;
   logic       r_err,    w_err_nxt;

   // Registered bus/response outputs. The next values are decoded from the
   // current state, so every output lags its state by one cycle. As a result,
   // the enable output is still high while the FSM sits in RESP. That is why
   // read data is sampled in RESP.
   addr_t r_reg_adr,   w_reg_adr_nxt;
   logic  r_adr_latch, w_adr_latch_nxt;
   logic  r_enable,    w_enable_nxt;
   logic  r_bus_we,    w_bus_we_nxt;
   data_t r_bus_wdata, w_bus_wdata_nxt;
   logic  r_rsp_valid, w_rsp_valid_nxt;
   logic  r_rsp_err,   w_rsp_err_nxt;
   data_t r_rsp_rdata, w_rsp_rdata_nxt;

   logic  w_accept;

   assign w_accept = bus.req_valid && (r_state == S_IDLE);

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_write_nxt     = r_write;
      w_err_nxt       = r_err;
      w_reg_adr_nxt   = '0;
      w_adr_latch_nxt = 1'b0;
      w_enable_nxt    = 1'b0;
      w_bus_we_nxt    = 1'b0;
      w_bus_wdata_nxt = '0;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_err_nxt   = 1'b0;
      w_rsp_rdata_nxt = r_rsp_rdata;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_addr_nxt  = bus.req_addr;
               w_wdata_nxt = bus.req_wdata;
               w_write_nxt = bus.req_write;
`ifdef REG_BUS_ADDR_CHECK_EN
               w_err_nxt   = !is_mapped(bus.req_addr);
`else
               w_err_nxt   = 1'b0;
`endif
               w_state_nxt = w_err_nxt ? S_RESP : S_ADDR;
            end
         end
         S_ADDR: begin
            w_reg_adr_nxt = r_addr;
            w_state_nxt   = S_LATCH;
         end
         S_LATCH: begin
            w_reg_adr_nxt   = r_addr;
            w_adr_latch_nxt = 1'b1;
            w_cnt_nxt       = c_cnt_load;
            w_state_nxt     = S_ENABLE;
         end
         S_ENABLE: begin
            w_reg_adr_nxt   = r_addr;
            w_enable_nxt    = 1'b1;
            w_bus_we_nxt    = r_write;
            w_bus_wdata_nxt = r_wdata;
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_RESP;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_RESP: begin
            // A rejected access never drove the bus, so it keeps regAdr at 0.
            w_reg_adr_nxt   = r_err ? '0 : r_addr;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = r_err;
            // The final enable cycle is on the bus now, so the decoder is
            // presenting the read data.
            if (!r_write && !r_err) begin
               w_rsp_rdata_nxt = bus.bus_rdata;
            end
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_write     <= 1'b0;
         r_err       <= 1'b0;
         r_reg_adr   <= '0;
         r_adr_latch <= 1'b0;
         r_enable    <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_wdata <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_write     <= w_write_nxt;
         r_err       <= w_err_nxt;
         r_reg_adr   <= w_reg_adr_nxt;
         r_adr_latch <= w_adr_latch_nxt;
         r_enable    <= w_enable_nxt;
         r_bus_we    <= w_bus_we_nxt;
         r_bus_wdata <= w_bus_wdata_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
      end
   end

   assign bus.req_ready     = (r_state == S_IDLE);
   assign bus.regAdr        = r_reg_adr;
   assign bus.clk_AdrLatch  = r_adr_latch;
   assign bus.enable_output = r_enable;
   assign bus.bus_we        = r_bus_we;
   assign bus.bus_wdata     = r_bus_wdata;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_err       = r_rsp_err;
   assign bus.rsp_rdata     = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_reg_bus_initiator
// Description : Directed testbench for reg_bus_initiator. The main instance
//               uses ENABLE_CYCLES=2 and has a decoder/register-bank model.
//               Two extra instances (ENABLE_CYCLES=1 and 15) share the request
//               inputs and are used for the enable-width/latency checks.
// Option      : REG_BUS_ADDR_CHECK_EN selects the expectations for addr 5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bus_initiator;
   import reg_bus_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       req_valid;
   logic       req_write;
   logic [3:0] req_addr;
   logic [7:0] req_wdata;

   int n_tests = 0;
   int n_fail  = 0;

   reg_bus_initiator_if bus2 ();
   reg_bus_initiator_if bus1 ();
   reg_bus_initiator_if bus15 ();

   assign bus2.req_valid  = req_valid;
   assign bus2.req_write  = req_write;
   assign bus2.req_addr   = req_addr;
   assign bus2.req_wdata  = req_wdata;
   assign bus1.req_valid  = req_valid;
   assign bus1.req_write  = req_write;
   assign bus1.req_addr   = req_addr;
   assign bus1.req_wdata  = req_wdata;
   assign bus15.req_valid = req_valid;
   assign bus15.req_write = req_write;
   assign bus15.req_addr  = req_addr;
   assign bus15.req_wdata = req_wdata;
   assign bus1.bus_rdata  = 8'h00;
   assign bus15.bus_rdata = 8'h00;

   reg_bus_initiator #(.ENABLE_CYCLES(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
   reg_bus_initiator #(.ENABLE_CYCLES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
   reg_bus_initiator #(.ENABLE_CYCLES(15)) dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15));

   // Decoder / register-bank model for the main instance
   logic [7:0] mem [16];
   logic [3:0] dec_addr;
   always @(negedge bus2.clk_AdrLatch) dec_addr <= bus2.regAdr;
   always @(posedge clk) if (bus2.enable_output && bus2.bus_we) mem[dec_addr] <= bus2.bus_wdata;
   assign bus2.bus_rdata = (bus2.enable_output && !bus2.bus_we) ? mem[dec_addr] : 8'h00;

   // Observations of one access on the main instance
   int         obs_rsp_k, obs_rsp_n, obs_latch_n, obs_en_n, obs_we_n, obs_wd_n, obs_adr_chg;
   logic       obs_err;
   logic [7:0] obs_rdata;
   logic [3:0] obs_latch_adr;

   task automatic run_access(input logic wr, input logic [3:0] a, input logic [7:0] d, input int cycles);
      logic [3:0] prev_adr;
      int waited;
      waited = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      while (bus2.req_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      obs_rsp_k = 0; obs_rsp_n = 0; obs_latch_n = 0; obs_en_n = 0;
      obs_we_n = 0; obs_wd_n = 0; obs_adr_chg = 0;
      obs_err = 1'b0; obs_rdata = 8'h00; obs_latch_adr = 4'h0;
      if (waited >= 50) begin
         n_tests++; n_fail++;
         $display("FAIL accept_timeout: req_ready=%b, required 1", bus2.req_ready);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      prev_adr = bus2.regAdr;
      for (int k = 1; k <= cycles; k++) begin
         @(posedge clk); #1;
         if (bus2.regAdr !== prev_adr) obs_adr_chg++;
         prev_adr = bus2.regAdr;
         if (bus2.clk_AdrLatch) begin
            obs_latch_n++;
            obs_latch_adr = bus2.regAdr;
         end
         if (bus2.enable_output) obs_en_n++;
         if (bus2.bus_we) obs_we_n++;
         if (bus2.enable_output && bus2.bus_wdata === d) obs_wd_n++;
         if (bus2.rsp_valid) begin
            obs_rsp_n++;
            if (obs_rsp_k == 0) obs_rsp_k = k;
            obs_err   = bus2.rsp_err;
            obs_rdata = bus2.rsp_rdata;
         end
      end
   endtask

   task automatic test_reset();
      logic [24:0] outs;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0; req_wdata = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      outs = {bus2.regAdr, bus2.clk_AdrLatch, bus2.enable_output, bus2.bus_we, bus2.bus_wdata,
              bus2.rsp_valid, bus2.rsp_err, bus2.rsp_rdata};
      n_tests++;
      if (outs !== 25'h0) begin n_fail++; $display("FAIL reset_outputs: got %h, required 0", outs); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus2.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", bus2.req_ready); end
   endtask

   task automatic test_write();
      run_access(1'b1, 4'd9, 8'hA5, 8);
      n_tests++;
      if (obs_latch_n !== 1) begin n_fail++; $display("FAIL wr_latch_width: got %0d, required 1", obs_latch_n); end
      n_tests++;
      if (obs_latch_adr !== 4'd9) begin n_fail++; $display("FAIL wr_latch_adr: got %0d, required 9", obs_latch_adr); end
      n_tests++;
      if (obs_en_n !== 2) begin n_fail++; $display("FAIL wr_enable_width: got %0d, required 2", obs_en_n); end
      n_tests++;
      if (obs_we_n !== 2) begin n_fail++; $display("FAIL wr_we_width: got %0d, required 2", obs_we_n); end
      n_tests++;
      if (obs_wd_n !== 2) begin n_fail++; $display("FAIL wr_wdata_cycles: got %0d, required 2", obs_wd_n); end
      n_tests++;
      if (obs_rsp_k !== 5 || obs_rsp_n !== 1) begin n_fail++; $display("FAIL wr_latency: got k=%0d n=%0d, required k=5 n=1", obs_rsp_k, obs_rsp_n); end
      n_tests++;
      if (dec_addr !== c_adr_data2) begin n_fail++; $display("FAIL wr_decoder_select: got %0d, required 9", dec_addr); end
      n_tests++;
      if (obs_rdata !== 8'h00 || obs_err !== 1'b0) begin n_fail++; $display("FAIL wr_rsp: got rdata=%h err=%b, required 00/0", obs_rdata, obs_err); end
      n_tests++;
      if (obs_adr_chg !== 2) begin n_fail++; $display("FAIL wr_regadr_changes: got %0d, required 2", obs_adr_chg); end
   endtask

   task automatic test_read();
      run_access(1'b0, 4'd0, 8'h00, 8);
      n_tests++;
      if (obs_rdata !== 8'h3C) begin n_fail++; $display("FAIL rd_data: got %h, required 3c", obs_rdata); end
      n_tests++;
      if (obs_err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b, required 0", obs_err); end
      n_tests++;
      if (obs_we_n !== 0) begin n_fail++; $display("FAIL rd_we: got %0d cycles, required 0", obs_we_n); end
      n_tests++;
      if (obs_rsp_k !== 5) begin n_fail++; $display("FAIL rd_latency: got %0d, required 5", obs_rsp_k); end
   endtask

   task automatic test_back_to_back();
      int rsp_a, rsp_b, rdy_n, chg, waited;
      logic [7:0] rd_a, rd_b;
      logic [3:0] prev;
      rsp_a = 0; rsp_b = 0; rdy_n = 0; chg = 0; waited = 0; rd_a = 8'h00; rd_b = 8'h00;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd1; req_wdata = 8'h00;
      while (bus2.req_ready !== 1'b1 && waited < 50) begin @(negedge clk); waited++; end
      @(posedge clk); #1;
      req_addr = 4'd2;
      prev = bus2.regAdr;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (k <= 10 && bus2.req_ready === 1'b1) rdy_n++;
         if (bus2.regAdr !== prev) chg++;
         prev = bus2.regAdr;
         if (bus2.rsp_valid === 1'b1) begin
            if (rsp_a == 0) begin rsp_a = k; rd_a = bus2.rsp_rdata; end
            else if (rsp_b == 0) begin rsp_b = k; rd_b = bus2.rsp_rdata; end
         end
         if (k == 6) req_valid = 1'b0;
      end
      n_tests++;
      if (rsp_a !== 5 || rsp_b !== 11) begin n_fail++; $display("FAIL b2b_rsp_cycles: got %0d,%0d, required 5,11", rsp_a, rsp_b); end
      n_tests++;
      if (rd_a !== 8'h11 || rd_b !== 8'h22) begin n_fail++; $display("FAIL b2b_rdata: got %h,%h, required 11,22", rd_a, rd_b); end
      n_tests++;
      if (rdy_n !== 1) begin n_fail++; $display("FAIL b2b_ready_cycles: got %0d, required 1", rdy_n); end
      n_tests++;
      if (chg !== 4) begin n_fail++; $display("FAIL b2b_regadr_changes: got %0d, required 4", chg); end
   endtask

   task automatic test_readback();
      run_access(1'b0, 4'd9, 8'h00, 8);
      n_tests++;
      if (obs_rdata !== 8'hA5 || obs_rsp_k !== 5) begin n_fail++; $display("FAIL readback: got %h at %0d, required a5 at 5", obs_rdata, obs_rsp_k); end
   endtask

   task automatic test_unmapped();
      run_access(1'b0, 4'd5, 8'h00, 8);
`ifdef REG_BUS_ADDR_CHECK_EN
      n_tests++;
      if (obs_rsp_k !== 1 || obs_err !== 1'b1) begin n_fail++; $display("FAIL unmapped_rsp: got k=%0d err=%b, required k=1 err=1", obs_rsp_k, obs_err); end
      n_tests++;
      if (obs_latch_n !== 0 || obs_en_n !== 0) begin n_fail++; $display("FAIL unmapped_bus: got latch=%0d en=%0d, required 0/0", obs_latch_n, obs_en_n); end
      n_tests++;
      if (obs_rdata !== 8'hA5) begin n_fail++; $display("FAIL unmapped_rdata: got %h, required a5", obs_rdata); end
`else
      n_tests++;
      if (obs_rsp_k !== 5 || obs_err !== 1'b0) begin n_fail++; $display("FAIL unmapped_rsp: got k=%0d err=%b, required k=5 err=0", obs_rsp_k, obs_err); end
      n_tests++;
      if (obs_latch_n !== 1 || obs_en_n !== 2) begin n_fail++; $display("FAIL unmapped_bus: got latch=%0d en=%0d, required 1/2", obs_latch_n, obs_en_n); end
      n_tests++;
      if (obs_rdata !== 8'h77) begin n_fail++; $display("FAIL unmapped_rdata: got %h, required 77", obs_rdata); end
`endif
   endtask

   task automatic test_reset_mid_access();
      logic [24:0] outs;
      int rsp_n, en_n, waited;
      rsp_n = 0; en_n = 0; waited = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd10; req_wdata = 8'h5A;
      while (bus2.req_ready !== 1'b1 && waited < 50) begin @(negedge clk); waited++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (bus2.enable_output !== 1'b1) begin n_fail++; $display("FAIL mid_in_enable: got %b, required 1", bus2.enable_output); end
      #2 rst_n = 1'b0;
      #1;
      outs = {bus2.regAdr, bus2.clk_AdrLatch, bus2.enable_output, bus2.bus_we, bus2.bus_wdata,
              bus2.rsp_valid, bus2.rsp_err, bus2.rsp_rdata};
      n_tests++;
      if (outs !== 25'h0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h, required 0", outs); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (bus2.rsp_valid === 1'b1) rsp_n++;
         if (bus2.enable_output === 1'b1) en_n++;
      end
      n_tests++;
      if (rsp_n !== 0 || en_n !== 0) begin n_fail++; $display("FAIL mid_reset_abort: got rsp=%0d en=%0d, required 0/0", rsp_n, en_n); end
      n_tests++;
      if (bus2.req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b, required 1", bus2.req_ready); end
      run_access(1'b0, 4'd9, 8'h00, 8);
      n_tests++;
      if (obs_rdata !== 8'hA5 || obs_rsp_k !== 5 || obs_rsp_n !== 1) begin
         n_fail++; $display("FAIL mid_reset_recover: got %h k=%0d n=%0d, required a5 k=5 n=1", obs_rdata, obs_rsp_k, obs_rsp_n);
      end
   endtask

   task automatic test_enable_cycles();
      int en1, en2, en15, rsp1, rsp2, rsp15, waited;
      en1 = 0; en2 = 0; en15 = 0; rsp1 = 0; rsp2 = 0; rsp15 = 0; waited = 0;
      @(negedge clk);
      while (!(bus1.req_ready === 1'b1 && bus2.req_ready === 1'b1 && bus15.req_ready === 1'b1) && waited < 60) begin
         @(negedge clk); waited++;
      end
      n_tests++;
      if (waited >= 60) begin n_fail++; $display("FAIL ncyc_idle_timeout: got busy, required all ready"); end
      req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd8; req_wdata = 8'h01;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         @(posedge clk); #1;
         if (bus1.enable_output === 1'b1) en1++;
         if (bus2.enable_output === 1'b1) en2++;
         if (bus15.enable_output === 1'b1) en15++;
         if (bus1.rsp_valid === 1'b1 && rsp1 == 0) rsp1 = k;
         if (bus2.rsp_valid === 1'b1 && rsp2 == 0) rsp2 = k;
         if (bus15.rsp_valid === 1'b1 && rsp15 == 0) rsp15 = k;
      end
      n_tests++;
      if (en1 !== 1 || rsp1 !== 4) begin n_fail++; $display("FAIL ncyc_1: got en=%0d lat=%0d, required en=1 lat=4", en1, rsp1); end
      n_tests++;
      if (en2 !== 2 || rsp2 !== 5) begin n_fail++; $display("FAIL ncyc_2: got en=%0d lat=%0d, required en=2 lat=5", en2, rsp2); end
      n_tests++;
      if (en15 !== 15 || rsp15 !== 18) begin n_fail++; $display("FAIL ncyc_15: got en=%0d lat=%0d, required en=15 lat=18", en15, rsp15); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[0] = 8'h3C;
      mem[1] = 8'h11;
      mem[2] = 8'h22;
      mem[5] = 8'h77;
      dec_addr = 4'h0;
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_readback();
      test_unmapped();
      test_reset_mid_access();
      test_enable_cycles();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
